// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray step decoder: FSM state encoding,
// transition delta classes and the gray-to-binary conversion.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ERROR = 2'b10
  } state_e;

  localparam logic [1:0] D_HOLD = 2'd0;
  localparam logic [1:0] D_UP   = 2'd1;
  localparam logic [1:0] D_ILL  = 2'd2;
  localparam logic [1:0] D_DN   = 2'd3;

  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/gray_step_classify.sv
// Combinational transition classifier: modulo-4 difference between the new
// binary sample and the previous one, mapped directly onto the delta classes.
module gray_step_classify
  import gray_pkg::*;
(
  input  logic [1:0] prev_i,
  input  logic [1:0] bin_i,
  output logic [1:0] delta_o
);

  // 2-bit subtraction wraps naturally, giving hold/up/illegal/down.
  assign delta_o = bin_i - prev_i;

endmodule

// File: rtl/gray_step_decoder.sv
// Gray step decoder top: IDLE/TRACK/ERROR FSM, signed position accumulator and
// step/err pulses. Define GRAY_DEC_ERR_CNT_EN to add the saturating err_cnt port.
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [1:0]       gray_in,
  input  logic             in_valid,
  input  logic             pos_clr,
  output logic [1:0]       bin_out,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err,
`ifdef GRAY_DEC_ERR_CNT_EN
  output logic [ERR_W-1:0] err_cnt,
`endif
  output logic             locked
);

  // Handshake: gray_in is consumed on every clk edge where in_valid=1; there
  // is no backpressure, and in_valid=0 cycles leave all tracking state intact.

  state_e           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic [1:0]       b_new;
  logic [1:0]       delta;

  assign b_new = gray2bin(gray_in);

  gray_step_classify u_classify (
    .prev_i  (prev_q),
    .bin_i   (b_new),
    .delta_o (delta)
  );

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          prev_d  = b_new;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (in_valid) begin
          prev_d = b_new;
          case (delta)
            D_UP: begin
              pos_d  = pos_q + CNT_W'(1);
              dir_d  = 1'b1;
              step_d = 1'b1;
            end
            D_DN: begin
              pos_d  = pos_q - CNT_W'(1);
              dir_d  = 1'b0;
              step_d = 1'b1;
            end
            D_ILL: begin
              err_d   = 1'b1;
              state_d = ERROR;
            end
            default: ;
          endcase
        end
      end
      ERROR: begin
        // Resync sample is a new reference only, never judged as a jump.
        if (in_valid) begin
          prev_d  = b_new;
          state_d = TRACK;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pos_clr) pos_d = '0;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      prev_q  <= 2'b00;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

`ifdef GRAY_DEC_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (arst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  // bin_out is the same register as the reference sample.
  assign bin_out = prev_q;
  assign pos     = pos_q;
  assign dir     = dir_q;
  assign step    = step_q;
  assign err     = err_q;
  assign locked  = (state_q == TRACK);

endmodule

// File: tb/tb_gray_step_decoder.sv
// Self-checking bench for gray_step_decoder: directed scenarios plus random
// traffic, scoreboarded against a behavioural model of the decoder rules.
module tb_gray_step_decoder;

  localparam int CNT_W = 8;
  localparam int ERR_W = 4;
  localparam int EXP_W = 1 + 1 + 1 + 1 + CNT_W + 2 + ERR_W;

  logic             clk;
  logic             arst;
  logic [1:0]       gray_in;
  logic             in_valid;
  logic             pos_clr;
  logic [1:0]       bin_out;
  logic [CNT_W-1:0] pos;
  logic             dir;
  logic             step;
  logic             err;
  logic             locked;
`ifdef GRAY_DEC_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt;
`endif

  gray_step_decoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .arst     (arst),
    .gray_in  (gray_in),
    .in_valid (in_valid),
    .pos_clr  (pos_clr),
    .bin_out  (bin_out),
    .pos      (pos),
    .dir      (dir),
    .step     (step),
    .err      (err),
`ifdef GRAY_DEC_ERR_CNT_EN
    .err_cnt  (err_cnt),
`endif
    .locked   (locked)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 = waiting for a reference sample, 1 = tracking, 2 = after an illegal jump
  int m_mode;
  int m_prev;
  int m_pos;   // kept in 0 .. 2^CNT_W-1
  int m_dir;
  int m_errs;
  int gray_seq[4] = '{0, 1, 3, 2};

  logic [EXP_W-1:0] exp_q[$];
  int checks;
  int errors;

  function automatic int gray_to_index(input int g);
    for (int i = 0; i < 4; i++) if (gray_seq[i] == g) return i;
    return 0;
  endfunction

  task automatic cycle(input logic v, input logic [1:0] g, input logic clr, input logic rst);
    int e_step, e_err, b, d, modulus;
    logic [EXP_W-1:0] e;
    modulus = 1 << CNT_W;
    @(negedge clk);
    arst     = rst;
    in_valid = v;
    gray_in  = g;
    pos_clr  = clr;
    e_step = 0;
    e_err  = 0;
    if (rst) begin
      m_mode = 0; m_prev = 0; m_pos = 0; m_dir = 0; m_errs = 0;
    end else begin
      if (v) begin
        b = gray_to_index(int'(g));
        if (m_mode == 1) begin
          d = (b - m_prev + 4) % 4;
          if (d == 1) begin
            m_pos = (m_pos + 1) % modulus; m_dir = 1; e_step = 1;
          end else if (d == 3) begin
            m_pos = (m_pos + modulus - 1) % modulus; m_dir = 0; e_step = 1;
          end else if (d == 2) begin
            e_err = 1; m_mode = 2;
            if (m_errs < (1 << ERR_W) - 1) m_errs++;
          end
        end else begin
          m_mode = 1;
        end
        m_prev = b;
      end
      if (clr) m_pos = 0;
    end
    e = {(m_mode == 1) ? 1'b1 : 1'b0, e_err[0], e_step[0], m_dir[0],
         m_pos[CNT_W-1:0], m_prev[1:0], m_errs[ERR_W-1:0]};
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [EXP_W-1:0] e, a;
    logic [ERR_W-1:0] a_cnt;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
`ifdef GRAY_DEC_ERR_CNT_EN
      a_cnt = err_cnt;
`else
      a_cnt = e[ERR_W-1:0];
`endif
      a = {locked, err, step, dir, pos, bin_out, a_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got locked=%b err=%b step=%b dir=%b pos=%0d bin=%0d err_cnt=%0d, expected locked=%b err=%b step=%b dir=%b pos=%0d bin=%0d err_cnt=%0d",
                 $time, a[EXP_W-1], a[EXP_W-2], a[EXP_W-3], a[EXP_W-4],
                 $signed(a[EXP_W-5 -: CNT_W]), a[ERR_W+1 -: 2], a[ERR_W-1:0],
                 e[EXP_W-1], e[EXP_W-2], e[EXP_W-3], e[EXP_W-4],
                 $signed(e[EXP_W-5 -: CNT_W]), e[ERR_W+1 -: 2], e[ERR_W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] g_up[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  initial begin
    int drain;
    checks = 0; errors = 0;
    arst = 1'b1; in_valid = 1'b0; gray_in = 2'b00; pos_clr = 1'b0;
    m_mode = 0; m_prev = 0; m_pos = 0; m_dir = 0; m_errs = 0;

    // Up sequence: reference then four up-steps.
    cycle(0, 2'b00, 0, 1);
    cycle(0, 2'b00, 0, 1);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 0);

    // Down sequence to -3.
    cycle(0, 2'b00, 0, 1);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b01, 0, 0);

    // Illegal jump, then resync.
    cycle(0, 2'b00, 0, 1);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b11, 0, 0);

    // Climb to 127, wrap to -128, then clear together with an up-step.
    cycle(0, 2'b00, 0, 1);
    cycle(1, 2'b00, 0, 0);
    for (int i = 1; i <= 128; i++) cycle(1, g_up[i % 4], 0, 0);
    cycle(1, g_up[129 % 4], 1, 0);
    cycle(1, g_up[130 % 4], 0, 0);

    // in_valid low while gray_in moves, then reset mid-sequence.
    for (int i = 0; i < 6; i++) cycle(0, 2'($urandom_range(0, 3)), 0, 0);
    cycle(1, g_up[3], 0, 0);
    cycle(0, 2'b01, 0, 1);
    cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b11, 0, 0);

    // Twenty illegal jumps, each followed by a resync on the same value.
    cycle(0, 2'b00, 0, 1);
    cycle(1, 2'b00, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, (i % 2 == 0) ? 2'b11 : 2'b00, 0, 0);
      cycle(1, (i % 2 == 0) ? 2'b11 : 2'b00, 0, 0);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    cycle(0, 2'b00, 0, 0);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_step_decoder.md
Name: gray_step_decoder

Overview:
- Downstream consumer of the 2-bit Moore gray counter output (y[1:0]).
- Samples the incoming gray code and converts it to binary.
- Classifies each transition as up-step, down-step, hold or illegal jump.
- Maintains a signed position accumulator and step/error status for the next stage (display or checker logic).

Parameters:
- CNT_W, 8: width of the signed two's-complement position accumulator.
- ERR_W, 4: width of the saturating illegal-jump counter (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising-edge active.
- arst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- gray_in  input  2  gray code from the counter stage.
- in_valid  input  1  gray_in is sampled only on cycles where in_valid=1.
- pos_clr  input  1  synchronous clear of the position accumulator.
- bin_out  output  2  registered binary equivalent of the last accepted sample.
- pos  output  CNT_W  signed position; +1 per up-step, -1 per down-step.
- dir  output  1  direction of the last valid step (1=up, 0=down).
- step  output  1  one-cycle pulse on each legal step.
- err  output  1  one-cycle pulse on an illegal jump.
- locked  output  1  high while in TRACK.
- err_cnt  output  ERR_W  saturating illegal-jump count; present only with GRAY_DEC_ERR_CNT_EN.

Behaviour:
- Reset (arst=1 at a clk edge):
  - state=IDLE; internal prev=0.
  - bin_out=0, pos=0, dir=0, step=0, err=0, locked=0, err_cnt=0.
  - arst has priority over every other input.
- Conversion: b[1]=g[1]; b[0]=g[1]^g[0]. Sequence 00,01,11,10 maps to binary 0,1,2,3.
- All outputs are registered. Latency from an accepted sample to the updated outputs is 1 clk.
- in_valid=0: state, prev, pos, dir and bin_out hold; step=0, err=0.
- State IDLE, in_valid=1:
  - prev and bin_out take the converted sample.
  - Go to TRACK; locked=1.
  - No step or err pulse.
- State TRACK, in_valid=1: delta = (b_new - prev) mod 4.
  - delta=0: hold; no pulse.
  - delta=1: pos=pos+1; dir=1; step=1.
  - delta=3: pos=pos-1; dir=0; step=1.
  - delta=2 (both gray bits changed):
    - err=1; pos and dir unchanged.
    - Go to ERROR; locked=0.
  - prev and bin_out update in every case above.
- State ERROR, in_valid=1:
  - Resync: prev and bin_out take the sample; go to TRACK; locked=1.
  - No step or err pulse, even if the sample would be a second illegal jump.
- pos wraps modulo 2^CNT_W. Example with CNT_W=8: 127+1 -> -128, and -128-1 -> 127.
- pos_clr=1:
  - pos=0 on the next edge.
  - If a step occurs in the same cycle, the clear wins: pos=0, but dir and step still reflect the step.
- Reset mid-operation: the first valid sample after reset is treated as a reference sample only; it produces no step.
- States are IDLE, TRACK and ERROR, encoded in 2 bits. The unused encoding returns to IDLE.

Optional Feature:
- Macro: GRAY_DEC_ERR_CNT_EN.
- Defined:
  - The err_cnt port exists.
  - It increments on each err pulse and saturates at 2^ERR_W-1.
  - It clears only on arst.
- Undefined:
  - The err_cnt port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package gray_pkg holds:
  - state enum: IDLE=2'b00, TRACK=2'b01, ERROR=2'b10.
  - delta constants: D_HOLD=0, D_UP=1, D_ILL=2, D_DN=3.
  - conversion function gray2bin.
- One natural sub-module, gray_step_classify: combinational; takes prev and b_new, outputs delta class.
- FSM, accumulator and counters stay in the top module.

Test Plan:
- Reset, then valid gray sequence 00,01,11,10,00:
  - First sample gives step=0, locked=1.
  - Next four samples give four step pulses, dir=1, pos=4.
  - bin_out follows 0,1,2,3,0.
- After locking at 00, feed 10,11,01: three steps, dir=0, pos=-3 (8'hFD).
- Locked at 00, feed 11 (illegal jump):
  - err=1 for one cycle, locked=0, pos unchanged.
  - Next valid sample 01 resyncs: locked=1, step=0.
  - With GRAY_DEC_ERR_CNT_EN, err_cnt=1.
- Drive pos=127 by repeated up-steps, then one more up-step: pos=-128. Assert pos_clr together with an up-step: pos=0, step=1.
- Toggle in_valid=0 while gray_in changes: no pulses, outputs hold. Assert arst mid-sequence: all outputs return to their reset values, and the next sample produces no step.
- With GRAY_DEC_ERR_CNT_EN and ERR_W=4, force 20 illegal jumps (each followed by resync): err_cnt saturates at 15.
